// File: rtl/obtc_job_dispatcher.sv
// Pairs consecutive 256-bit gatherer words into mining jobs, holds one job pending,
// and hands it round-robin to the next idle hashing core with a disjoint nonce range.
module obtc_job_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_in,
    input  logic [255:0]         din,
    input  logic [NUM_CORES-1:0] core_busy,
    output logic [NUM_CORES-1:0] core_we,
    output logic [255:0]         core_midstate,
    output logic [255:0]         core_data,
    output logic [31:0]          core_nonce_start,
    output logic                 pend_valid,
    output logic [31:0]          job_cnt,
    output logic [15:0]          drop_cnt
);

    typedef enum logic {
        WORD0 = 1'b0,
        WORD1 = 1'b1
    } coll_state_e;

    coll_state_e state_q, state_d;

    logic [255:0]         midstate_c_q;
    logic [255:0]         midstate_p_q;
    logic [255:0]         data_p_q;
    logic                 pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_CORES-1:0] core_we_q, core_we_d;
    logic [255:0]         core_midstate_q, core_midstate_d;
    logic [255:0]         core_data_q, core_data_d;
    logic [31:0]          core_nonce_start_q, core_nonce_start_d;
    logic [31:0]          job_cnt_q, job_cnt_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic                 word0_cap;
    logic                 job_done;
    logic                 pend_load;
    logic                 job_drop;
    logic                 found;
    logic                 dispatch;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand;

    // Collection FSM: alternate word 0 / word 1 on each we_in strobe.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        word0_cap = 1'b0;
        job_done  = 1'b0;
        case (state_q)
            WORD0: begin
                if (we_in) begin
                    word0_cap = 1'b1;
                    state_d   = WORD1;
                end
            end
            WORD1: begin
                if (we_in) begin
                    job_done = 1'b1;
                    state_d  = WORD0;
                end
            end
            default: state_d = WORD0;
        endcase
    end

    // Round-robin search from rr_ptr; the core strobed last cycle is masked
    // because its busy flag has not risen yet. Index wrap relies on NUM_CORES
    // being a power of two.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = rr_ptr_q + IDX_W'(k);
            if (!found && !core_busy[cand] && !core_we_q[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign dispatch  = pend_valid_q && found;
    assign pend_load = job_done && (!pend_valid_q || dispatch);
    assign job_drop  = job_done && pend_valid_q && !dispatch;

    always_comb begin
        pend_valid_d       = pend_valid_q;
        rr_ptr_d           = rr_ptr_q;
        core_we_d          = '0;
        core_midstate_d    = core_midstate_q;
        core_data_d        = core_data_q;
        core_nonce_start_d = core_nonce_start_q;
        job_cnt_d          = job_cnt_q;
        drop_cnt_d         = drop_cnt_q;

        if (dispatch) begin
            core_we_d[sel_idx] = 1'b1;
            core_midstate_d    = midstate_p_q;
            core_data_d        = data_p_q;
            core_nonce_start_d = {sel_idx, {(32-IDX_W){1'b0}}};
            rr_ptr_d           = sel_idx + 1'b1;
            job_cnt_d          = job_cnt_q + 32'd1;
            pend_valid_d       = 1'b0;
        end

        if (pend_load) begin
            pend_valid_d = 1'b1;
        end

        if (job_drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= WORD0;
            pend_valid_q       <= 1'b0;
            rr_ptr_q           <= '0;
            core_we_q          <= '0;
            core_midstate_q    <= '0;
            core_data_q        <= '0;
            core_nonce_start_q <= '0;
            job_cnt_q          <= '0;
            drop_cnt_q         <= '0;
        end else begin
            state_q            <= state_d;
            pend_valid_q       <= pend_valid_d;
            rr_ptr_q           <= rr_ptr_d;
            core_we_q          <= core_we_d;
            core_midstate_q    <= core_midstate_d;
            core_data_q        <= core_data_d;
            core_nonce_start_q <= core_nonce_start_d;
            job_cnt_q          <= job_cnt_d;
            drop_cnt_q         <= drop_cnt_d;
        end
    end

    // NOTE: the collection and pending buffers carry no reset; they are only
    // ever read after the control state above has marked them as loaded.
    always_ff @(posedge clk) begin
        if (word0_cap) begin
            midstate_c_q <= din;
        end
        if (pend_load) begin
            midstate_p_q <= midstate_c_q;
            data_p_q     <= din;
        end
    end

    assign core_we          = core_we_q;
    assign core_midstate    = core_midstate_q;
    assign core_data        = core_data_q;
    assign core_nonce_start = core_nonce_start_q;
    assign pend_valid       = pend_valid_q;
    assign job_cnt          = job_cnt_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_obtc_job_dispatcher.sv
// Self-checking bench for obtc_job_dispatcher: a job-level reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_obtc_job_dispatcher;

    localparam int NUM_CORES = 4;

    localparam logic [255:0] A  = {8{32'hA0A0_0001}};
    localparam logic [255:0] B  = {8{32'hB0B0_0002}};
    localparam logic [255:0] X1 = {8{32'h1111_0001}};
    localparam logic [255:0] Y1 = {8{32'h2222_0001}};
    localparam logic [255:0] X2 = {8{32'h1111_0002}};
    localparam logic [255:0] Y2 = {8{32'h2222_0002}};
    localparam logic [255:0] P0 = {8{32'hC0FF_EE00}};
    localparam logic [255:0] P1 = {8{32'hC0FF_EE01}};
    localparam logic [255:0] Q0 = {8{32'hDEAD_0000}};
    localparam logic [255:0] Q1 = {8{32'hDEAD_0001}};
    localparam logic [255:0] Z0 = {8{32'h5A5A_5A5A}};
    localparam logic [255:0] C  = {8{32'hCCCC_0003}};
    localparam logic [255:0] D  = {8{32'hDDDD_0004}};

    logic                 clk;
    logic                 rst;
    logic                 we_in;
    logic [255:0]         din;
    logic [NUM_CORES-1:0] core_busy;
    logic [NUM_CORES-1:0] core_we;
    logic [255:0]         core_midstate;
    logic [255:0]         core_data;
    logic [31:0]          core_nonce_start;
    logic                 pend_valid;
    logic [31:0]          job_cnt;
    logic [15:0]          drop_cnt;

    int total = 0;
    int bad   = 0;
    bit started  = 1'b0;
    bit auto_busy = 1'b0;
    logic [NUM_CORES-1:0] prev_we = '0;

    obtc_job_dispatcher #(.NUM_CORES(NUM_CORES)) dut (
        .clk              (clk),
        .rst              (rst),
        .we_in            (we_in),
        .din              (din),
        .core_busy        (core_busy),
        .core_we          (core_we),
        .core_midstate    (core_midstate),
        .core_data        (core_data),
        .core_nonce_start (core_nonce_start),
        .pend_valid       (pend_valid),
        .job_cnt          (job_cnt),
        .drop_cnt         (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one pending job slot, a half-built job, a round-robin
    // pointer and the core handed a job last cycle (which cannot take another yet).
    logic [NUM_CORES-1:0] m_we;
    logic [255:0]         m_mid, m_data, m_pmid, m_pdata, m_w0;
    logic [31:0]          m_nonce, m_job;
    logic [15:0]          m_drop;
    bit                   m_pend, m_have_w0;
    int                   m_rr, m_last;

    always @(posedge clk) begin
        int pick;
        if (rst) begin
            m_we = '0; m_mid = '0; m_data = '0; m_nonce = '0;
            m_job = '0; m_drop = '0; m_pend = 1'b0; m_have_w0 = 1'b0;
            m_rr = 0; m_last = -1;
        end else begin
            pick = -1;
            if (m_pend) begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    int c;
                    c = (m_rr + k) % NUM_CORES;
                    if (pick < 0 && !core_busy[c] && c != m_last) pick = c;
                end
            end
            m_we = '0;
            if (pick >= 0) begin
                m_we[pick] = 1'b1;
                m_mid   = m_pmid;
                m_data  = m_pdata;
                m_nonce = 32'((longint'(pick) << 32) / NUM_CORES);
                m_rr    = (pick + 1) % NUM_CORES;
                m_job   = m_job + 32'd1;
                m_pend  = 1'b0;
            end
            m_last = pick;
            if (we_in) begin
                if (!m_have_w0) begin
                    m_w0 = din;
                    m_have_w0 = 1'b1;
                end else begin
                    m_have_w0 = 1'b0;
                    if (!m_pend) begin
                        m_pend  = 1'b1;
                        m_pmid  = m_w0;
                        m_pdata = din;
                    end else if (m_drop != 16'hFFFF) begin
                        m_drop = m_drop + 16'd1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        check("model core_we",    256'(core_we),          256'(m_we));
        check("model pend_valid", 256'(pend_valid),       256'(m_pend));
        check("model job_cnt",    256'(job_cnt),          256'(m_job));
        check("model drop_cnt",   256'(drop_cnt),         256'(m_drop));
        check("model midstate",   core_midstate,          m_mid);
        check("model data",       core_data,              m_data);
        check("model nonce",      256'(core_nonce_start), 256'(m_nonce));
    endtask

    // One clock; the emulated cores raise busy the cycle after they see a strobe.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_busy) core_busy = core_busy | prev_we;
        prev_we = core_we;
    endtask

    task automatic send_word(input logic [255:0] w);
        we_in = 1'b1;
        din   = w;
        tick();
        we_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic lit(input string name, input logic [255:0] act, input logic [255:0] exp);
        check(name, act, exp);
    endtask

    logic [31:0] nonce_tab [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};

    initial begin
        rst = 1'b1; we_in = 1'b0; din = '0; core_busy = '0;

        fork
            forever begin
                @(negedge clk);
                if (started) compare_model();
            end
        join_none

        // Reset then idle.
        tick(); tick();
        started = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lit("idle core_we", 256'(core_we), 256'(0));
            lit("idle pend_valid", 256'(pend_valid), 256'(0));
            lit("idle job_cnt", 256'(job_cnt), 256'(0));
            lit("idle drop_cnt", 256'(drop_cnt), 256'(0));
        end

        // Single job A/B with 4-cycle word spacing.
        send_word(A);
        tick(); tick(); tick();
        send_word(B);
        lit("ab pend_valid", 256'(pend_valid), 256'(1));
        lit("ab core_we early", 256'(core_we), 256'(0));
        tick();
        lit("ab core_we", 256'(core_we), 256'(4'b0001));
        lit("ab midstate", core_midstate, A);
        lit("ab data", core_data, B);
        lit("ab nonce", 256'(core_nonce_start), 256'(32'h0));
        lit("ab job_cnt", 256'(job_cnt), 256'(1));
        tick();
        lit("ab strobe one cycle", 256'(core_we), 256'(0));

        // Four jobs across idle cores that turn busy after their strobe.
        core_busy = '0;
        do_reset();
        auto_busy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            send_word(X1 ^ 256'(j));
            send_word(Y1 ^ 256'(j));
            tick();
            lit("rr core_we", 256'(core_we), 256'(4'b0001 << j));
            lit("rr nonce", 256'(core_nonce_start), 256'(nonce_tab[j]));
            lit("rr midstate", core_midstate, X1 ^ 256'(j));
            tick();
        end
        auto_busy = 1'b0;

        // Core 2 busy before the third job: it goes to core 3.
        core_busy = '0;
        do_reset();
        for (int j = 0; j < 2; j++) begin
            send_word(X2); send_word(Y2); tick();
            lit("skip early core_we", 256'(core_we), 256'(4'b0001 << j));
            tick();
        end
        core_busy = 4'b0100;
        send_word(X2); send_word(Y2); tick();
        lit("skip busy core_we", 256'(core_we), 256'(4'b1000));
        lit("skip busy nonce", 256'(core_nonce_start), 256'(32'hC000_0000));
        tick();

        // All cores busy: first job waits, second is dropped, core 2 frees.
        core_busy = 4'b1111;
        do_reset();
        send_word(X1); send_word(Y1); tick();
        lit("full pend", 256'(pend_valid), 256'(1));
        send_word(X2); send_word(Y2);
        lit("full drop_cnt", 256'(drop_cnt), 256'(1));
        lit("full no strobe", 256'(core_we), 256'(0));
        core_busy = 4'b1011;
        tick();
        lit("full core_we", 256'(core_we), 256'(4'b0100));
        lit("full midstate", core_midstate, X1);
        lit("full data", core_data, Y1);
        lit("full pend after", 256'(pend_valid), 256'(0));

        // Completion on the same edge as a dispatch.
        core_busy = 4'b1111;
        do_reset();
        send_word(P0); send_word(P1);
        send_word(Q0);
        core_busy = 4'b1110;
        we_in = 1'b1; din = Q1;
        tick();
        we_in = 1'b0;
        lit("same core_we", 256'(core_we), 256'(4'b0001));
        lit("same midstate", core_midstate, P0);
        lit("same pend", 256'(pend_valid), 256'(1));
        lit("same drop_cnt", 256'(drop_cnt), 256'(0));
        core_busy = 4'b1111;
        tick();
        lit("same wait", 256'(core_we), 256'(0));
        core_busy = 4'b1101;
        tick();
        lit("same core_we 2", 256'(core_we), 256'(4'b0010));
        lit("same midstate 2", core_midstate, Q0);
        lit("same data 2", core_data, Q1);
        lit("same nonce 2", 256'(core_nonce_start), 256'(32'h4000_0000));
        lit("same job_cnt", 256'(job_cnt), 256'(2));

        // Reset mid-job, then a fresh C/D job; then reset during a strobe.
        core_busy = '0;
        do_reset();
        send_word(Z0);
        do_reset();
        lit("mid-rst job_cnt", 256'(job_cnt), 256'(0));
        send_word(C); send_word(D);
        lit("mid-rst pend", 256'(pend_valid), 256'(1));
        lit("mid-rst job_cnt pre", 256'(job_cnt), 256'(0));
        lit("mid-rst drop_cnt pre", 256'(drop_cnt), 256'(0));
        tick();
        lit("mid-rst core_we", 256'(core_we), 256'(4'b0001));
        lit("mid-rst midstate", core_midstate, C);
        lit("mid-rst data", core_data, D);
        do_reset();
        lit("strobe-rst core_we", 256'(core_we), 256'(0));
        lit("strobe-rst midstate", core_midstate, 256'(0));
        tick();
        lit("strobe-rst quiet", 256'(core_we), 256'(0));

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
